// File: rtl/pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pool_window_feeder
// Brief    : Raster feature beats -> per-channel vertical MAXPOOL_SIZE-row
//            windows for the pooling array. Optional top padding with the
//            most-negative value when POOL_FEEDER_PAD_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module pool_window_feeder #(
    parameter int FEATURE_WIDTH  = 16,
    parameter int MAXPOOL_SIZE   = 5,
    parameter int PE_ARRAY_SIZE  = 8,
    parameter int MAX_LINE_WIDTH = 64,
    parameter int DIM_WIDTH      = 8
) (
    input  logic                                                DSP_clk,
    input  logic                                                rst_n,
    input  logic                                                start,
    input  logic [DIM_WIDTH-1:0]                                cfg_width,
    input  logic [DIM_WIDTH-1:0]                                cfg_height,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [FEATURE_WIDTH*PE_ARRAY_SIZE-1:0]              in_feature,
    output logic [FEATURE_WIDTH*MAXPOOL_SIZE*PE_ARRAY_SIZE-1:0] feature_out,
    output logic                                                pulse,
    output logic                                                row_first,
    output logic                                                busy,
    output logic                                                done
);
    localparam int NBUF   = MAXPOOL_SIZE - 1;
    localparam int SEL_W  = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int ADDR_W = (MAX_LINE_WIDTH > 1) ? $clog2(MAX_LINE_WIDTH) : 1;
    localparam int BEAT_W = FEATURE_WIDTH * PE_ARRAY_SIZE;
    localparam int WIN_W  = BEAT_W * MAXPOOL_SIZE;
`ifdef POOL_FEEDER_PAD_EN
    localparam int FIRST_ROW  = 0;
    localparam int MIN_HEIGHT = 1;
    localparam logic [FEATURE_WIDTH-1:0] PAD_VALUE = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};
`else
    localparam int FIRST_ROW  = NBUF;
    localparam int MIN_HEIGHT = MAXPOOL_SIZE;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [DIM_WIDTH-1:0] col, row, width_q, height_q;
    logic [SEL_W-1:0]     wr_sel;
    logic [BEAT_W-1:0]    line_mem [NBUF][MAX_LINE_WIDTH];
    logic [BEAT_W-1:0]    rd_beat  [NBUF];
    logic [WIN_W-1:0]     window;
    logic                 cfg_ok, accept, last_col, last_row, frame_go;

    assign cfg_ok   = (cfg_width != '0) && (int'(cfg_width) <= MAX_LINE_WIDTH)
                      && (int'(cfg_height) >= MIN_HEIGHT);
    assign frame_go = (state == ST_IDLE) && start && cfg_ok;
    assign in_ready = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign last_col = (col == width_q - DIM_WIDTH'(1));
    assign last_row = (row == height_q - DIM_WIDTH'(1));

    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (frame_go) state_nx = ST_RUN;
            ST_RUN:   if (accept && last_col && last_row) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Buffer wr_sel holds the oldest row; the others follow it in rotation order.
    for (genvar j = 0; j < NBUF; j++) begin : g_rd
        logic [SEL_W-1:0] sel;
        assign sel = (int'(wr_sel) + j >= NBUF) ? SEL_W'(int'(wr_sel) + j - NBUF)
                                                : SEL_W'(int'(wr_sel) + j);
        assign rd_beat[j] = line_mem[sel][col[ADDR_W-1:0]];
    end

    for (genvar i = 0; i < PE_ARRAY_SIZE; i++) begin : g_ch
        for (genvar j = 0; j < MAXPOOL_SIZE; j++) begin : g_row
            if (j == NBUF) begin : g_cur
                assign window[(i*MAXPOOL_SIZE+j)*FEATURE_WIDTH +: FEATURE_WIDTH] =
                    in_feature[i*FEATURE_WIDTH +: FEATURE_WIDTH];
            end else begin : g_old
`ifdef POOL_FEEDER_PAD_EN
                assign window[(i*MAXPOOL_SIZE+j)*FEATURE_WIDTH +: FEATURE_WIDTH] =
                    (int'(row) < NBUF - j) ? PAD_VALUE
                                           : rd_beat[j][i*FEATURE_WIDTH +: FEATURE_WIDTH];
`else
                assign window[(i*MAXPOOL_SIZE+j)*FEATURE_WIDTH +: FEATURE_WIDTH] =
                    rd_beat[j][i*FEATURE_WIDTH +: FEATURE_WIDTH];
`endif
            end
        end
    end

    // Line buffers are never reset: a location is always written before it is emitted.
    always_ff @(posedge DSP_clk) begin
        if (accept) line_mem[wr_sel][col[ADDR_W-1:0]] <= in_feature;
    end

    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            wr_sel      <= '0;
            width_q     <= '0;
            height_q    <= '0;
            feature_out <= '0;
            pulse       <= 1'b0;
            row_first   <= 1'b0;
            done        <= 1'b0;
        end else begin
            pulse     <= 1'b0;
            row_first <= 1'b0;
            done      <= 1'b0;
            if (frame_go) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                col      <= '0;
                row      <= '0;
                wr_sel   <= '0;
            end
            if (accept) begin
                if (int'(row) >= FIRST_ROW) begin
                    feature_out <= window;
                    pulse       <= 1'b1;
                    row_first   <= (col == '0);
                end
                if (last_col) begin
                    col    <= '0;
                    row    <= row + DIM_WIDTH'(1);
                    wr_sel <= (wr_sel == SEL_W'(NBUF - 1)) ? '0 : wr_sel + SEL_W'(1);
                    done   <= last_row;
                end else begin
                    col <= col + DIM_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_window_feeder
// Brief    : Randomized self-checking bench for pool_window_feeder against a
//            frame-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pool_window_feeder;
    localparam int FW = 16, MP = 5, PE = 8, MLW = 64, DW = 8;
    localparam int BW = FW * PE, OW = BW * MP;
`ifdef POOL_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          DSP_clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] cfg_width = '0, cfg_height = '0;
    logic [BW-1:0] in_feature = '0;
    logic          in_ready, pulse, row_first, busy, done;
    logic [OW-1:0] feature_out;

    int n_vec = 0, n_err = 0, dut_pulses = 0;

    // Reference model: whole frame stored, windows rebuilt from absolute row indices.
    logic [BW-1:0] frame [256][64];
    bit            m_run = 1'b0, m_flush = 1'b0;
    int            m_r = 0, m_c = 0, m_w = 0, m_h = 0;
    logic [OW-1:0] m_win = '0;

    pool_window_feeder #(
        .FEATURE_WIDTH(FW), .MAXPOOL_SIZE(MP), .PE_ARRAY_SIZE(PE),
        .MAX_LINE_WIDTH(MLW), .DIM_WIDTH(DW)
    ) dut (
        .DSP_clk(DSP_clk), .rst_n(rst_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
        .feature_out(feature_out), .pulse(pulse), .row_first(row_first),
        .busy(busy), .done(done)
    );

    always #5 DSP_clk = ~DSP_clk;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cfg_valid(input int w, input int h);
        return (w >= 1) && (w <= MLW) && (h >= (PAD ? 1 : MP));
    endfunction

    function automatic logic [OW-1:0] exp_window(input int r, input int c);
        logic [OW-1:0] win;
        int fr;
        win = '0;
        for (int i = 0; i < PE; i++)
            for (int j = 0; j < MP; j++) begin
                fr = r - (MP - 1 - j);
                win[(i*MP+j)*FW +: FW] = (fr < 0) ? 16'h8000 : frame[fr][c][i*FW +: FW];
            end
        return win;
    endfunction

    function automatic logic [BW-1:0] make_beat(input int mode, input int r, input int c);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < PE; i++)
            case (mode)
                0:       b[i*FW +: FW] = FW'(r * 16 + c);
                1:       b[i*FW +: FW] = FW'(i * 256 + r * 16 + c);
                default: b[i*FW +: FW] = FW'($urandom);
            endcase
        return b;
    endfunction

    // One clock: drive inputs, advance model, check registered outputs after the edge.
    task automatic step(input bit v, input bit st, input logic [BW-1:0] d);
        bit acc, e_pulse, e_first, e_done, was_idle;
        in_valid   = v;
        start      = st;
        in_feature = d;
        check("in_ready", OW'(in_ready), OW'(m_run));
        check("busy", OW'(busy), OW'(m_run | m_flush));
        acc      = v && m_run;
        was_idle = !m_run && !m_flush;
        e_pulse  = 1'b0;
        e_first  = 1'b0;
        e_done   = 1'b0;
        m_flush  = 1'b0;
        if (acc) begin
            frame[m_r][m_c] = d;
            if (PAD || m_r >= MP - 1) begin
                e_pulse = 1'b1;
                e_first = (m_c == 0);
                m_win   = exp_window(m_r, m_c);
            end
            if (m_r == m_h - 1 && m_c == m_w - 1) begin
                m_run   = 1'b0;
                m_flush = 1'b1;
                e_done  = 1'b1;
            end else if (m_c == m_w - 1) begin
                m_c = 0;
                m_r++;
            end else begin
                m_c++;
            end
        end else if (was_idle && st && cfg_valid(int'(cfg_width), int'(cfg_height))) begin
            m_run = 1'b1;
            m_r   = 0;
            m_c   = 0;
            m_w   = int'(cfg_width);
            m_h   = int'(cfg_height);
        end
        @(posedge DSP_clk);
        #1;
        if (pulse === 1'b1) dut_pulses++;
        check("pulse", OW'(pulse), OW'(e_pulse));
        check("done", OW'(done), OW'(e_done));
        if (e_pulse) check("row_first", OW'(row_first), OW'(e_first));
        check("feature_out", feature_out, m_win);
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random. dmode selects beat pattern.
    task automatic run_frame(input int w, input int h, input int vmode, input int dmode,
                             input bit poke_start);
        int guard, p0;
        bit v;
        guard      = 0;
        p0         = dut_pulses;
        cfg_width  = DW'(w);
        cfg_height = DW'(h);
        step(1'b0, 1'b1, '0);
        cfg_width  = DW'($urandom_range(1, 64));
        cfg_height = DW'($urandom_range(5, 9));
        while (m_run && guard < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            step(v, poke_start && ($urandom_range(0, 7) == 0), make_beat(dmode, m_r, m_c));
            guard++;
        end
        check("frame_timeout", OW'(m_run), OW'(0));
        step(1'($urandom_range(0, 1)), 1'b0, '0);
        check("pulse_count", OW'(dut_pulses - p0), OW'(PAD ? w * h : w * (h - MP + 1)));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", OW'(in_ready), OW'(0));
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_pulse", OW'(pulse), OW'(0));
        check("rst_row_first", OW'(row_first), OW'(0));
        check("rst_done", OW'(done), OW'(0));
        check("rst_feature_out", feature_out, '0);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        #20 rst_n = 1'b1;
        @(posedge DSP_clk);
        #1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, make_beat(2, 0, 0));

        // Rejected configurations leave the feeder idle.
        cfg_width = 8'd0;  cfg_height = 8'd5;  step(1'b1, 1'b1, '0); step(1'b1, 1'b0, '0);
        cfg_width = 8'd65; cfg_height = 8'd5;  step(1'b1, 1'b1, '0); step(1'b1, 1'b0, '0);
        cfg_width = 8'd4;  cfg_height = PAD ? 8'd0 : 8'd4;
        step(1'b1, 1'b1, '0); step(1'b1, 1'b0, '0);

        run_frame(4, 5, 0, 0, 1'b0);
        run_frame(3, 7, 1, 0, 1'b1);
        run_frame(8, 6, 2, 1, 1'b1);
        run_frame(64, 5, 0, 2, 1'b1);
        for (int k = 0; k < 4; k++)
            run_frame($urandom_range(1, 10), $urandom_range(PAD ? 1 : MP, 9), 2, 2, 1'b1);
`ifdef POOL_FEEDER_PAD_EN
        run_frame(2, 2, 0, 0, 1'b0);
`endif

        // Reset mid-frame after two rows of a width-8 frame.
        cfg_width = 8'd8; cfg_height = 8'd6;
        step(1'b0, 1'b1, '0);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, make_beat(2, m_r, m_c));
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_run = 1'b0; m_flush = 1'b0; m_win = '0;
        @(posedge DSP_clk);
        #1;
        rst_n = 1'b1;
        run_frame(8, 5, 0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
